cart_bus_reader: RTL and testbench

Single-byte read sequencer between the cartridge-facing logic (header verifier, camera register access) and the physical Game Boy cartridge pins. It accepts one read request at a time over a request/busy handshake. It drives the address bus, `/RD` and `/CS` with programmable setup, strobe and recovery timing, and samples the data bus through a two-flop synchronizer. The captured byte is returned with a one-cycle valid pulse. The block is read-only and never drives the cartridge data bus.

---
 rtl/cart_bus_reader.sv | 100 ++++++++++
 tb/tb_cart_bus_reader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cart_bus_reader.sv
// Single-byte cartridge read sequencer: drives address, /RD and /CS with
// programmable setup/strobe/recovery timing and samples the data pins through a 2-flop synchronizer.
module cart_bus_reader #(
  parameter int SETUP_CYCLES   = 4,
  parameter int STROBE_CYCLES  = 16,
  parameter int RECOVER_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [15:0] addr,
  output logic        busy,
  output logic        data_valid,
  output logic [7:0]  data_out,
  output logic [15:0] cart_a,
  output logic        cart_rd_n,
  output logic        cart_cs_n,
  input  logic [7:0]  cart_d
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 255 ||
      STROBE_CYCLES < 3 || STROBE_CYCLES > 255 ||
      RECOVER_CYCLES < 1 || RECOVER_CYCLES > 255) begin : g_bad_params
    $error("cart_bus_reader: timing parameter out of range");
  end

  localparam logic [7:0] SETUP_LD   = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LD  = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] RECOVER_LD = 8'(RECOVER_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [7:0] d_s1, d_s2;
  logic       cap;

  assign cap = (state == STROBE) && (cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      d_s1       <= 8'd0;
      d_s2       <= 8'd0;
      cart_a     <= 16'd0;
      data_out   <= 8'd0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      d_s1       <= cart_d;
      d_s2       <= d_s1;
      data_valid <= cap;
      if (cap)
        data_out <= d_s2;
      // cart_a doubles as the latched request address
      if (state == IDLE && req)
        cart_a <= addr;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:
        if (req) begin
          state_nxt = SETUP;
          cnt_nxt   = SETUP_LD;
        end
      SETUP:
        if (cnt == 8'd0) begin
          state_nxt = STROBE;
          cnt_nxt   = STROBE_LD;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      STROBE:
        if (cnt == 8'd0) begin
          state_nxt = RECOVER;
          cnt_nxt   = RECOVER_LD;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      RECOVER:
        if (cnt == 8'd0)
          state_nxt = IDLE;
        else
          cnt_nxt = cnt - 8'd1;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign cart_rd_n = (state != STROBE);
  // /CS follows the address for the whole SETUP+STROBE window in the RAM region
  assign cart_cs_n = !(((state == SETUP) || (state == STROBE)) && (cart_a >= 16'hA000));

endmodule

// File: tb/tb_cart_bus_reader.sv
// Bench for cart_bus_reader: default-timing and minimum-timing instances share stimulus,
// each checked every cycle against a transaction-offset timing model plus directed spot checks.
module tb_cart_bus_reader;

  logic        clk = 1'b0;
  logic        reset, req;
  logic [15:0] addr;
  logic [7:0]  cart_d;

  logic [1:0]        busy_w, valid_w, rd_n_w, cs_n_w;
  logic [1:0][7:0]   dout_w;
  logic [1:0][15:0]  a_w;

  always #5 clk = ~clk;

  cart_bus_reader u_def (
    .clk(clk), .reset(reset), .req(req), .addr(addr),
    .busy(busy_w[0]), .data_valid(valid_w[0]), .data_out(dout_w[0]),
    .cart_a(a_w[0]), .cart_rd_n(rd_n_w[0]), .cart_cs_n(cs_n_w[0]), .cart_d(cart_d)
  );

  cart_bus_reader #(.SETUP_CYCLES(1), .STROBE_CYCLES(3), .RECOVER_CYCLES(1)) u_min (
    .clk(clk), .reset(reset), .req(req), .addr(addr),
    .busy(busy_w[1]), .data_valid(valid_w[1]), .data_out(dout_w[1]),
    .cart_a(a_w[1]), .cart_rd_n(rd_n_w[1]), .cart_cs_n(cs_n_w[1]), .cart_d(cart_d)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a transaction is its start edge t0; every output is a function of
  // the offset from t0 and the S/R/C timing windows.
  int          PS[2] = '{4, 1};
  int          PR[2] = '{16, 3};
  int          PC[2] = '{4, 1};
  bit          m_act[2];
  int          m_t0[2];
  logic [15:0] m_a[2];
  logic [7:0]  m_d[2];
  logic [7:0]  pin_hist[$];
  int          edge_n = 0;

  task automatic model_edge();
    pin_hist.push_back(cart_d);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_act[i] = 0; m_a[i] = 16'd0; m_d[i] = 8'd0;
      end else begin
        if (m_act[i] && edge_n - m_t0[i] == PS[i] + PR[i])
          m_d[i] = pin_hist[edge_n - 2];
        if (m_act[i] && edge_n - m_t0[i] > PS[i] + PR[i] + PC[i])
          m_act[i] = 0;
        if (!m_act[i] && req) begin
          m_act[i] = 1; m_t0[i] = edge_n; m_a[i] = addr;
        end
      end
    end
    edge_n++;
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int off;
      bit b, rdl, csl, v;
      off = edge_n - m_t0[i];
      b   = m_act[i] && off >= 1 && off <= PS[i] + PR[i] + PC[i];
      rdl = m_act[i] && off >= PS[i] + 1 && off <= PS[i] + PR[i];
      csl = m_act[i] && off >= 1 && off <= PS[i] + PR[i] && m_a[i] >= 16'hA000;
      v   = m_act[i] && off == PS[i] + PR[i] + 1;
      chk($sformatf("u%0d busy", i),  32'(busy_w[i]), 32'(b));
      chk($sformatf("u%0d rd_n", i),  32'(rd_n_w[i]), 32'(!rdl));
      chk($sformatf("u%0d cs_n", i),  32'(cs_n_w[i]), 32'(!csl));
      chk($sformatf("u%0d valid", i), 32'(valid_w[i]), 32'(v));
      chk($sformatf("u%0d cart_a", i), 32'(a_w[i]), 32'(m_a[i]));
      chk($sformatf("u%0d dout", i),  32'(dout_w[i]), 32'(m_d[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] d0, input logic [7:0] d1,
                    input int chg, input logic [7:0] exp_d);
    req = 1'b1; addr = a; cart_d = d0;
    step();
    req = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      if (c == chg) cart_d = d1;
      step();
    end
    chk($sformatf("rd_data %h", a), 32'(dout_w[0]), 32'(exp_d));
  endtask

  initial begin
    int npulse, first_pulse, gap;
    reset = 1'b1; req = 1'b1; addr = 16'hBEEF; cart_d = 8'h00;
    for (int k = 0; k < 3; k++) step();
    chk("reset busy", 32'(busy_w[0]), 32'd0);
    chk("reset cart_a", 32'(a_w[0]), 32'd0);
    reset = 1'b0;

    // minimum timing: valid in cycle 5, next accept at edge 6
    req = 1'b1; addr = 16'hA123; cart_d = 8'h3C;
    step();
    for (int c = 1; c <= 7; c++) begin
      if (c == 5) begin
        chk("min valid c5", 32'(valid_w[1]), 32'd1);
        chk("min dout c5", 32'(dout_w[1]), 32'h3C);
      end
      if (c == 6) chk("min busy c6", 32'(busy_w[1]), 32'd0);
      if (c == 7) chk("min busy c7", 32'(busy_w[1]), 32'd1);
      step();
    end
    req = 1'b0;
    for (int k = 0; k < 25; k++) step();

    rd(16'h0134, 8'h47, 8'h47, 0,  8'h47);
    rd(16'hA000, 8'h12, 8'h12, 0,  8'h12);
    rd(16'h9FFF, 8'h34, 8'h34, 0,  8'h34);
    rd(16'h0150, 8'h00, 8'h5A, 10, 8'h5A);
    rd(16'h0150, 8'h00, 8'h5A, 20, 8'h00);

    // back-to-back with req held high
    req = 1'b1; addr = 16'h0134; cart_d = 8'h66;
    npulse = 0; first_pulse = 0; gap = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (c == 0) addr = 16'h0135;
      if (c == 25) req = 1'b0;
      if (valid_w[0]) begin
        if (npulse == 0) first_pulse = c; else gap = c - first_pulse;
        npulse++;
      end
    end
    chk("b2b pulses", 32'(npulse), 32'd2);
    chk("b2b gap", 32'(gap), 32'd25);

    // reset in the middle of STROBE
    req = 1'b1; addr = 16'h0200; cart_d = 8'h77;
    step();
    req = 1'b0;
    for (int c = 1; c <= 9; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst rd_n", 32'(rd_n_w[0]), 32'd1);
    chk("rst cart_a", 32'(a_w[0]), 32'd0);
    chk("rst busy", 32'(busy_w[0]), 32'd0);
    chk("rst dout", 32'(dout_w[0]), 32'd0);
    step();
    req = 1'b1; addr = 16'h0134; cart_d = 8'h11;
    step();
    req = 1'b0;
    npulse = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (valid_w[0]) npulse++;
    end
    chk("rst recover pulses", 32'(npulse), 32'd1);
    chk("rst recover data", 32'(dout_w[0]), 32'h11);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      req    = ($urandom_range(0, 99) < 30);
      addr   = $urandom_range(0, 1) ? 16'($urandom_range(16'hA000, 16'hFFFF)) : 16'($urandom);
      cart_d = 8'($urandom);
      reset  = ($urandom_range(0, 199) < 3);
      step();
    end
    reset = 1'b0; req = 1'b0;
    for (int k = 0; k < 30; k++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
